// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch entry type and opcode constants for the CPU
// front end. Imported by the fetch queue and its FIFO.
package cpu_pkg;
  localparam int          WORD_W  = 32;
  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  // One buffered fetch result: the PC it was read from and the word returned.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Major opcodes (inst[31:26]).
  localparam logic [5:0] OP_JUMP = 6'b000010;
  localparam logic [5:0] OP_BBT  = 6'b111111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage.
//   clk, reset  : clock, synchronous active-high reset (clears storage too)
//   flush       : empties the queue (pointers/count only)
//   push/data_i : enqueue; accepted when not full or when popping same cycle
//   pop         : dequeue; ignored when empty
//   count_o     : entries held, head_o : oldest entry (registered storage)
module sync_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end. Streams sequential PCs to a
// one-cycle-latency SRAM, buffers {pc, inst} pairs, hands them to decode
// over valid/ready, and restarts on redirect.
//   clk, reset                        : clock, sync active-high reset
//   inst_sram_en/addr/rdata           : SRAM read port (data next cycle)
//   redirect_valid/redirect_pc        : flush and restart at target
//   out_valid/out_ready/out_pc/out_inst : decode handshake, queue head
//   occupancy                         : entries currently queued
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int          CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          inst_sram_en,
  output logic [31:0]   inst_sram_addr,
  input  logic [31:0]   inst_sram_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic [CW-1:0] occupancy
);
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_q, inflight_d;
  logic [CW:0]  used;
  logic         issue, push, pop;
  fetch_entry_t push_entry, head;
  logic         unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Credit check: a request is only issued if its response is guaranteed
  // a slot, counting the one still in flight.
  assign used  = {1'b0, occupancy} + (CW+1)'(inflight_q);
  assign issue = !reset && !redirect_valid && (used < (CW+1)'(DEPTH));

  assign inst_sram_en   = issue;
  assign inst_sram_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // A redirect discards the returning response and any handshake this cycle.
  assign push            = inflight_q && !redirect_valid;
  assign pop             = out_valid && out_ready && !redirect_valid;
  assign push_entry.pc   = inflight_pc_q;
  assign push_entry.inst = inst_sram_rdata;

  sync_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .count_o (occupancy),
    .head_o  (head)
  );

  assign out_valid = (occupancy != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;
  logic [$clog2(DEPTH):0] occupancy;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // SRAM: data for an enabled read appears next cycle; junk otherwise.
  always @(posedge clk) inst_sram_rdata <= inst_sram_en ? (inst_sram_addr ^ K) : $urandom;

  // Reference model: queue of {pc, inst}, next fetch PC, outstanding read.
  logic [63:0] mq[$];
  logic [31:0] m_fpc = RESET_PC;
  logic [31:0] m_ipc = '0;
  int          m_infl = 0;
  int          checks = 0, errors = 0;

  logic        s_en, s_vld;
  logic [31:0] s_addr, s_pc, s_inst;
  int          s_occ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                      input bit rdy, input bit chk = 1'b1);
    bit exp_en;
    @(negedge clk);
    reset = r; redirect_valid = rd; redirect_pc = rpc; out_ready = rdy;
    #1;
    s_en = inst_sram_en; s_addr = inst_sram_addr; s_vld = out_valid;
    s_pc = out_pc; s_inst = out_inst; s_occ = int'(occupancy);
    exp_en = !r && !rd && ((mq.size() + m_infl) < DEPTH);
    if (chk) begin
      check("en", 32'(s_en), 32'(exp_en));
      check("valid", 32'(s_vld), 32'(mq.size() != 0));
      check("occupancy", 32'(s_occ), 32'(mq.size()));
      if (exp_en) check("addr", s_addr, m_fpc);
      if (mq.size() != 0) begin
        check("head_pc", s_pc, mq[0][63:32]);
        check("head_inst", s_inst, mq[0][31:0]);
      end
    end
    if (r) begin
      mq.delete(); m_infl = 0; m_fpc = RESET_PC;
    end else if (rd) begin
      mq.delete(); m_infl = 0; m_fpc = {rpc[31:2], 2'b00};
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_infl != 0) mq.push_back({m_ipc, m_ipc ^ K});
      if (exp_en) begin
        m_ipc = m_fpc; m_infl = 1; m_fpc = m_fpc + 32'd4;
      end else m_infl = 0;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  initial begin
    int nf;
    step(1, 0, 0, 0, 1'b0);
    step(1, 0, 0, 0);

    // Streaming from reset with decode always ready.
    step(0, 0, 0, 1);
    check("t1_en0", 32'(s_en), 1); check("t1_addr0", s_addr, 32'h0);
    step(0, 0, 0, 1);
    check("t1_addr1", s_addr, 32'h4); check("t1_vld_early", 32'(s_vld), 0);
    step(0, 0, 0, 1);
    check("t1_addr2", s_addr, 32'h8); check("t1_vld", 32'(s_vld), 1);
    check("t1_pc", s_pc, 32'h0); check("t1_inst", s_inst, 32'hA5A5_0000);
    step(0, 0, 0, 1);
    check("t1_pc1", s_pc, 32'h4); check("t1_en3", 32'(s_en), 1);

    // Decode stalled: exactly DEPTH fetches, then drain in order.
    do_reset();
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      if (s_en) begin check("t2_addr", s_addr, 32'(4 * nf)); nf++; end
    end
    check("t2_nfetch", 32'(nf), 4);
    check("t2_occ", 32'(s_occ), 4); check("t2_head", s_pc, 32'h0);
    step(0, 0, 0, 1);
    check("t2_pop_pc", s_pc, 32'h0); check("t2_en_full", 32'(s_en), 0);
    step(0, 0, 0, 1);
    check("t2_en_after", 32'(s_en), 1); check("t2_addr10", s_addr, 32'h10);
    check("t2_pc4", s_pc, 32'h4);

    // Redirect with 3 queued and one in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0103, 1);
    check("t3_occ_before", 32'(s_occ), 3); check("t3_en_redir", 32'(s_en), 0);
    step(0, 0, 0, 1);
    check("t3_occ0", 32'(s_occ), 0); check("t3_addr100", s_addr, 32'h100);
    step(0, 0, 0, 1);
    check("t3_vld0", 32'(s_vld), 0); check("t3_addr104", s_addr, 32'h104);
    step(0, 0, 0, 1);
    check("t3_vld", 32'(s_vld), 1); check("t3_pc", s_pc, 32'h100);
    check("t3_inst", s_inst, 32'h100 ^ K);

    // Push and pop together with full credit.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("t4_occ", 32'(s_occ), 3); check("t4_pc0", s_pc, 32'h0);
    step(0, 0, 0, 0);
    check("t4_occ_same", 32'(s_occ), 3); check("t4_pc4", s_pc, 32'h4);
    check("t4_addr10", s_addr, 32'h10);

    // Reset mid-stream.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t5_occ_before", 32'(s_occ), 2); check("t5_en_rst", 32'(s_en), 0);
    step(0, 0, 0, 0);
    check("t5_vld", 32'(s_vld), 0); check("t5_occ", 32'(s_occ), 0);
    check("t5_addr", s_addr, RESET_PC);
    step(0, 0, 0, 0);
    check("t5_no_stale", 32'(s_occ), 0);
    step(0, 0, 0, 0);
    check("t5_pc", s_pc, RESET_PC);

    // Address wrap.
    step(0, 1, 32'hFFFF_FFF8, 1);
    step(0, 0, 0, 1); check("t6_a0", s_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 1); check("t6_a1", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1); check("t6_a2", s_addr, 32'h0000_0000);
    check("t6_head", s_pc, 32'hFFFF_FFF8);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(199) == 0);
      rd  = ($urandom_range(15) == 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      rdy = (i % 400 < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      step(r, rd, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
